wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 33 +++
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result port, LSU result handshake,
// issue-time scoreboard update, and the registered register-file write port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] pending;
    logic        regf_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output lsu_ready, pending, regf_we, rd_addr, rd_wdata
    );

    // Pipeline / environment side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  lsu_ready, pending, regf_we, rd_addr, rd_wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the ALU has fixed priority onto a single register-file
// write port; load results queue in a small FIFO and drain in order whenever
// the ALU is idle. A pending-write scoreboard is set at issue and cleared when
// the matching write is registered.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          regf_we_q, regf_we_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_wdata_q, rd_wdata_d;
    logic [31:0]   pending_q, pending_d;

    logic          lsu_ready_s;
    logic          push_s;
    logic          pop_s;

    // Pointers wrap explicitly at FIFO_DEPTH rather than relying on overflow.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Ready depends only on registered occupancy, never on this cycle's valids.
    assign lsu_ready_s   = (count_q != CW'(FIFO_DEPTH));
    assign bus.lsu_ready = lsu_ready_s;
    assign bus.regf_we   = regf_we_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_wdata  = rd_wdata_q;
    assign bus.pending   = pending_q;

    // Select the next write (ALU first, then FIFO head), update FIFO
    // bookkeeping and the scoreboard.
    always_comb begin
        push_s     = bus.lsu_valid && lsu_ready_s;
        pop_s      = !bus.alu_valid && (count_q != '0);
        regf_we_d  = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_wdata_d = rd_wdata_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;

        if (bus.alu_valid) begin
            regf_we_d  = (bus.alu_rd != 5'd0);
            rd_addr_d  = bus.alu_rd;
            rd_wdata_d = bus.alu_data;
        end else if (pop_s) begin
            // An x0 head still pops; it just never raises the write enable.
            regf_we_d  = (fifo_rd_q[rd_ptr_q] != 5'd0);
            rd_addr_d  = fifo_rd_q[rd_ptr_q];
            rd_wdata_d = fifo_data_q[rd_ptr_q];
        end else begin
            regf_we_d  = 1'b0;
        end

        if (push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle issue to the same register wins.
        if (regf_we_d) begin
            pending_d[rd_addr_d] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // Control state, registered write port and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regf_we_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_wdata_q <= 32'd0;
            pending_q  <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            regf_we_q  <= regf_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
            pending_q  <= pending_d;
        end
    end

    // FIFO storage; contents are cleared on reset so nothing stale survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
            fifo_data_q[wr_ptr_q] <= bus.lsu_data;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written multi-cycle
// sequences (ALU starvation, async reset), then randomized traffic, all
// checked against a queue-based transaction model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if bus_if ();

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pend = 32'd0;
    logic        m_we   = 1'b0;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_data;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                          input logic iv, input logic [4:0] ird);
        bus_if.alu_valid   = av;
        bus_if.alu_rd      = ard;
        bus_if.alu_data    = adat;
        bus_if.lsu_valid   = lv;
        bus_if.lsu_rd      = lrd;
        bus_if.lsu_data    = ldat;
        bus_if.issue_valid = iv;
        bus_if.issue_rd    = ird;
    endtask

    // One clock of the transaction model plus comparison of the DUT outputs.
    task automatic cycle();
        logic   exp_ready;
        logic   have_sel;
        entry_t sel;
        sel       = '0;
        have_sel  = 1'b0;
        exp_ready = (mq.size() < DEPTH);
        check("lsu_ready", {31'd0, bus_if.lsu_ready}, {31'd0, exp_ready});
        if (bus_if.alu_valid) begin
            sel      = '{rd: bus_if.alu_rd, data: bus_if.alu_data};
            have_sel = 1'b1;
        end else if (mq.size() > 0) begin
            sel      = mq.pop_front();
            have_sel = 1'b1;
        end
        if (bus_if.lsu_valid && exp_ready)
            mq.push_back('{rd: bus_if.lsu_rd, data: bus_if.lsu_data});
        m_we = have_sel && (sel.rd != 5'd0);
        if (m_we) m_pend[sel.rd] = 1'b0;
        if (bus_if.issue_valid && bus_if.issue_rd != 5'd0) m_pend[bus_if.issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        check("regf_we", {31'd0, bus_if.regf_we}, {31'd0, m_we});
        if (m_we) begin
            check("rd_addr", {27'd0, bus_if.rd_addr}, {27'd0, sel.rd});
            check("rd_wdata", bus_if.rd_wdata, sel.data);
        end
        check("pending", bus_if.pending, m_pend);
    endtask

    initial begin
        int idx;
        logic rdy;

        //               alu v/rd/data            lsu v/rd/data          issue     exp we/addr/data           pend
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 5'd3, 32'h22,       1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b1, 5'd3, 32'h22,       32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd7, 32'h11,       32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        32'h200};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h200};
        tbl[7]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd9, 32'h99,       32'h0};
        tbl[8]  = '{1'b1, 5'd9, 32'h98,       1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 1'b1, 5'd9, 32'h98,       32'h200};
        tbl[9]  = '{1'b1, 5'd9, 32'h97,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd9, 32'h97,       32'h0};
        tbl[10] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};

        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #12;
        check("reset_we", {31'd0, bus_if.regf_we}, 32'd0);
        check("reset_addr", {27'd0, bus_if.rd_addr}, 32'd0);
        check("reset_data", bus_if.rd_wdata, 32'd0);
        check("reset_pending", bus_if.pending, 32'd0);
        check("reset_ready", {31'd0, bus_if.lsu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].alu_v, tbl[i].alu_rd, tbl[i].alu_data,
                   tbl[i].lsu_v, tbl[i].lsu_rd, tbl[i].lsu_data,
                   tbl[i].iss_v, tbl[i].iss_rd);
            cycle();
            check("tbl_we", {31'd0, bus_if.regf_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                check("tbl_addr", {27'd0, bus_if.rd_addr}, {27'd0, tbl[i].e_addr});
                check("tbl_data", bus_if.rd_wdata, tbl[i].e_data);
            end
            check("tbl_pend", bus_if.pending, tbl[i].e_pend);
        end

        // ALU holds the port for 6 cycles while the LSU offers x1, x2, x3.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, 5'(20 + c), 32'(c), idx < 3, 5'(idx + 1), 32'(256 + idx + 1), 1'b0, 5'd0);
            rdy = bus_if.lsu_ready;
            if (c == 2) check("full_ready", {31'd0, rdy}, 32'd0);
            cycle();
            if (bus_if.lsu_valid && rdy) idx++;
        end
        check("pushes_under_alu", 32'(idx), 32'd2);
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 5'd0, 32'd0, idx < 3, 5'(idx + 1), 32'(256 + idx + 1), 1'b0, 5'd0);
            rdy = bus_if.lsu_ready;
            cycle();
            if (bus_if.lsu_valid && rdy) idx++;
            if (c < 3) begin
                check("drain_we", {31'd0, bus_if.regf_we}, 32'd1);
                check("drain_order", {27'd0, bus_if.rd_addr}, 32'(c + 1));
            end
        end
        check("x3_accepted", 32'(idx), 32'd3);

        // Fill the FIFO under ALU priority, then pulse reset between edges.
        idx = 0;
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 5'd12, 32'hC0DE, 1'b1, 5'(14 + c), 32'(c), c == 0, 5'd4);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_we", {31'd0, bus_if.regf_we}, 32'd0);
        check("async_addr", {27'd0, bus_if.rd_addr}, 32'd0);
        check("async_data", bus_if.rd_wdata, 32'd0);
        check("async_pending", bus_if.pending, 32'd0);
        check("async_ready", {31'd0, bus_if.lsu_ready}, 32'd1);
        #1 rst_n = 1'b1;
        mq.delete();
        m_pend = 32'd0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("no_stale_write", {31'd0, bus_if.regf_we}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
            cycle();
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int c = 0; c < 4; c++) cycle();
        check("drained", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
